// File: rtl/etapa_id_param_if.sv
// etapa_id_param_if: bundle of fetch-side, writeback and ID/EX-side signals
// of the decode stage. The slave modport is the decode stage's view; master
// is the view of whatever surrounds it (fetch, writeback, execute).
interface etapa_id_param_if #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8
);
    localparam int VW = LANES * ELEM_W;

    // fetch side
    logic              in_valid;
    logic              in_ready;
    logic [13:0]       instruccion;
    logic              dec_rdv, dec_rds, dec_wrv, dec_wrs, sel_dest;
    // writeback side
    logic              wb_wrv, wb_wrs;
    logic [2:0]        wb_dir;
    logic [VW-1:0]     wb_data_vec;
    logic [ELEM_W-1:0] wb_data_sca;
    // ID/EX side
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        opcode;
    logic [2:0]        dir_dest_out;
    logic              dest_is_vec, dest_is_sca;
    logic [VW-1:0]     data_vec1, data_vec2;
    logic [ELEM_W-1:0] data_sca1;
    logic [7:0]        inmediato;
    logic [7:0]        shift;
    logic [VW-1:0]     VFS;

    modport slave (
        input  in_valid, instruccion, dec_rdv, dec_rds, dec_wrv, dec_wrs, sel_dest,
        input  wb_wrv, wb_wrs, wb_dir, wb_data_vec, wb_data_sca,
        input  out_ready,
        output in_ready, out_valid, opcode, dir_dest_out, dest_is_vec, dest_is_sca,
        output data_vec1, data_vec2, data_sca1, inmediato, shift, VFS
    );

    modport master (
        output in_valid, instruccion, dec_rdv, dec_rds, dec_wrv, dec_wrs, sel_dest,
        output wb_wrv, wb_wrs, wb_dir, wb_data_vec, wb_data_sca,
        output out_ready,
        input  in_ready, out_valid, opcode, dir_dest_out, dest_is_vec, dest_is_sca,
        input  data_vec1, data_vec2, data_sca1, inmediato, shift, VFS
    );
endinterface

// File: rtl/etapa_id_param.sv
// etapa_id_param: parametrised decode stage of the vector processor.
// Holds the vector/scalar register banks, a busy-bit scoreboard that stalls
// on RAW/WAW hazards against in-flight writebacks, and a registered ID/EX
// output with valid/ready handshake.
// Optional feature macro: WB_BYPASS_EN -- a writeback in the current cycle
// clears the hazard immediately and its data is forwarded into the capture.
module etapa_id_param #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int NVREG  = 8,   // <= 8, addressed by 3 bits
    parameter int NSREG  = 8    // >= LANES, <= 8
) (
    input logic              clk,
    input logic              rst,
    etapa_id_param_if.slave  bus
);
    localparam int VW = LANES * ELEM_W;

    // register banks and scoreboard
    logic [NVREG-1:0][VW-1:0]     vreg_q;
    logic [NSREG-1:0][ELEM_W-1:0] sreg_q;
    logic [NVREG-1:0]             busy_v_q, busy_v_d, set_v, clr_v, busy_v_eff;
    logic [NSREG-1:0]             busy_s_q, busy_s_d, set_s, clr_s, busy_s_eff;

    // ID/EX register
    logic              out_valid_q, out_valid_d;
    logic [3:0]        opcode_q;
    logic [2:0]        dest_q;
    logic              dvec_q, dsca_q;
    logic [VW-1:0]     dv1_q, dv2_q;
    logic [ELEM_W-1:0] ds1_q;
    logic [7:0]        imm_q, shift_q;

    logic [2:0]        src1, src2, dest;
    logic [VW-1:0]     rd_v1, rd_v2;
    logic [ELEM_W-1:0] rd_s;
    logic              bv_src1, bv_src2, bs_src, bv_dest, bs_dest;
    logic              hazard, in_ready, accept;

    assign src1 = bus.instruccion[5:3];
    assign src2 = bus.instruccion[2:0];
    assign dest = bus.sel_dest ? {1'b0, bus.instruccion[9:8]} : bus.instruccion[8:6];

    // per-register set/clear strobes; out-of-range addresses match nothing
    always_comb begin
        for (int i = 0; i < NVREG; i++) begin
            set_v[i] = accept && bus.dec_wrv && (dest == 3'(i));
            clr_v[i] = bus.wb_wrv && (bus.wb_dir == 3'(i));
        end
        for (int i = 0; i < NSREG; i++) begin
            set_s[i] = accept && bus.dec_wrs && (dest == 3'(i));
            clr_s[i] = bus.wb_wrs && (bus.wb_dir == 3'(i));
        end
        // set wins over a same-cycle clear so the new writer stays tracked
        busy_v_d = (busy_v_q & ~clr_v) | set_v;
        busy_s_d = (busy_s_q & ~clr_s) | set_s;
`ifdef WB_BYPASS_EN
        busy_v_eff = busy_v_q & ~clr_v;
        busy_s_eff = busy_s_q & ~clr_s;
`else
        busy_v_eff = busy_v_q;
        busy_s_eff = busy_s_q;
`endif
    end

    // busy lookups and asynchronous bank reads (with optional forwarding)
    always_comb begin
        bv_src1 = 1'b0; bv_src2 = 1'b0; bv_dest = 1'b0;
        bs_src  = 1'b0; bs_dest = 1'b0;
        rd_v1 = '0; rd_v2 = '0; rd_s = '0;
        for (int i = 0; i < NVREG; i++) begin
            if (src1 == 3'(i)) begin bv_src1 = busy_v_eff[i]; rd_v1 = vreg_q[i]; end
            if (src2 == 3'(i)) begin bv_src2 = busy_v_eff[i]; rd_v2 = vreg_q[i]; end
            if (dest == 3'(i)) bv_dest = busy_v_eff[i];
        end
        for (int i = 0; i < NSREG; i++) begin
            if (src2 == 3'(i)) begin bs_src = busy_s_eff[i]; rd_s = sreg_q[i]; end
            if (dest == 3'(i)) bs_dest = busy_s_eff[i];
        end
`ifdef WB_BYPASS_EN
        if (bus.wb_wrv && bus.wb_dir == src1 && int'(src1) < NVREG) rd_v1 = bus.wb_data_vec;
        if (bus.wb_wrv && bus.wb_dir == src2 && int'(src2) < NVREG) rd_v2 = bus.wb_data_vec;
        if (bus.wb_wrs && bus.wb_dir == src2 && int'(src2) < NSREG) rd_s  = bus.wb_data_sca;
`endif
    end

    assign hazard = (bus.dec_rdv && (bv_src1 || bv_src2)) ||
                    (bus.dec_rds && bs_src) ||
                    (bus.dec_wrv && bv_dest) ||
                    (bus.dec_wrs && bs_dest);
    assign in_ready    = !hazard && (!out_valid_q || bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign out_valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);

    // register banks: synchronous writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            vreg_q <= '0;
            sreg_q <= '0;
        end else begin
            for (int i = 0; i < NVREG; i++) if (clr_v[i]) vreg_q[i] <= bus.wb_data_vec;
            for (int i = 0; i < NSREG; i++) if (clr_s[i]) sreg_q[i] <= bus.wb_data_sca;
        end
    end

    // scoreboard busy bits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_v_q <= '0;
            busy_s_q <= '0;
        end else begin
            busy_v_q <= busy_v_d;
            busy_s_q <= busy_s_d;
        end
    end

    // ID/EX register: data loads only on accept, valid drains on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opcode_q <= '0; dest_q <= '0; dvec_q <= 1'b0; dsca_q <= 1'b0;
            dv1_q <= '0; dv2_q <= '0; ds1_q <= '0; imm_q <= '0; shift_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                opcode_q <= bus.instruccion[13:10];
                dest_q   <= dest;
                dvec_q   <= bus.dec_wrv;
                dsca_q   <= bus.dec_wrs;
                dv1_q    <= rd_v1;
                dv2_q    <= rd_v2;
                ds1_q    <= rd_s;
                imm_q    <= bus.instruccion[7:0];
                shift_q  <= {5'b0, bus.instruccion[5:3]};
            end
        end
    end

    // scalar registers 0..LANES-1 exported as one vector, reg 0 in the LSBs
    always_comb begin
        bus.VFS = '0;
        for (int i = 0; i < LANES; i++) bus.VFS[i*ELEM_W +: ELEM_W] = sreg_q[i];
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.opcode       = opcode_q;
    assign bus.dir_dest_out = dest_q;
    assign bus.dest_is_vec  = dvec_q;
    assign bus.dest_is_sca  = dsca_q;
    assign bus.data_vec1    = dv1_q;
    assign bus.data_vec2    = dv2_q;
    assign bus.data_sca1    = ds1_q;
    assign bus.inmediato    = imm_q;
    assign bus.shift        = shift_q;
endmodule

// File: tb/tb_etapa_id_param.sv
// tb_etapa_id_param: directed bench for the decode stage with LANES=4,
// ELEM_W=8. Inputs change and outputs are sampled on the falling edge.
module tb_etapa_id_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    etapa_id_param_if #(.LANES(4), .ELEM_W(8)) bus ();

    etapa_id_param #(.LANES(4), .ELEM_W(8), .NVREG(8), .NSREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.instruccion = '0;
        bus.dec_rdv = 0; bus.dec_rds = 0; bus.dec_wrv = 0; bus.dec_wrs = 0; bus.sel_dest = 0;
        bus.wb_wrv = 0; bus.wb_wrs = 0; bus.wb_dir = '0;
        bus.wb_data_vec = '0; bus.wb_data_sca = '0;
        bus.out_ready = 1;
    endtask

    initial begin
        idle();
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_data_vec1", bus.data_vec1,      32'd0);
        chk("rst_vfs",       bus.VFS,            32'd0);
        chk("rst_opcode",    32'(bus.opcode),    32'd0);

        // write v3, then read it
        rst = 0;
        bus.wb_wrv = 1; bus.wb_dir = 3'd3; bus.wb_data_vec = 32'h04030201;
        @(negedge clk);
        bus.wb_wrv = 0;
        bus.instruccion = {4'h1, 4'b0000, 3'd3, 3'd0};
        bus.dec_rdv = 1; bus.in_valid = 1;
        #1 chk("rd_v3_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("rd_v3_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_v3_data",  bus.data_vec1,      32'h04030201);
        chk("rd_v3_op",    32'(bus.opcode),    32'd1);
        chk("rd_v3_shift", 32'(bus.shift),     32'd3);

        // writer of v2, then a reader of v2 that must stall
        bus.instruccion = {4'h2, 1'b0, 3'd2, 6'd0};
        bus.dec_rdv = 0; bus.dec_wrv = 1;
        @(negedge clk);
        chk("wr_v2_dest",   32'(bus.dir_dest_out), 32'd2);
        chk("wr_v2_isvec",  32'(bus.dest_is_vec),  32'd1);
        bus.instruccion = {4'h3, 4'b0000, 3'd0, 3'd2};
        bus.dec_wrv = 0; bus.dec_rdv = 1;
        #1 chk("raw_stall", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("raw_drain", 32'(bus.out_valid), 32'd0);
        bus.wb_wrv = 1; bus.wb_dir = 3'd2; bus.wb_data_vec = 32'hAABBCCDD;
`ifdef WB_BYPASS_EN
        #1 chk("wb_cycle_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.wb_wrv = 0;
`else
        #1 chk("wb_cycle_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.wb_wrv = 0;
        chk("wb_after_valid", 32'(bus.out_valid), 32'd0);
        #1 chk("wb_after_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
`endif
        chk("raw_valid", 32'(bus.out_valid), 32'd1);
        chk("raw_data2", bus.data_vec2,      32'hAABBCCDD);
        chk("raw_op",    32'(bus.opcode),    32'd3);
        bus.dec_rdv = 0;

        // backpressure: hold outputs while out_ready=0
        bus.instruccion = {4'h5, 2'b00, 8'hA7};
        @(negedge clk);
        chk("bp_a_op",  32'(bus.opcode),    32'd5);
        chk("bp_a_imm", 32'(bus.inmediato), 32'hA7);
        bus.instruccion = {4'h6, 2'b00, 8'h3C};
        bus.out_ready = 0;
        #1 chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_op",    32'(bus.opcode),    32'd5);
        chk("bp_hold_imm",   32'(bus.inmediato), 32'hA7);
        bus.out_ready = 1;
        #1 chk("bp_ready_high", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_b_op",    32'(bus.opcode),    32'd6);
        chk("bp_b_imm",   32'(bus.inmediato), 32'h3C);
        chk("bp_b_shift", 32'(bus.shift),     32'd7);

        // destination select
        bus.instruccion = {4'h7, 2'b11, 8'h00}; bus.sel_dest = 1;
        @(negedge clk);
        chk("dest_short", 32'(bus.dir_dest_out), 32'd3);
        bus.instruccion = {4'h8, 1'b0, 3'b101, 6'd0}; bus.sel_dest = 0;
        @(negedge clk);
        chk("dest_long", 32'(bus.dir_dest_out), 32'd5);
        bus.in_valid = 0;

        // scalar bank and VFS
        bus.wb_wrs = 1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_dir = 3'(i);
            bus.wb_data_sca = 8'(8'h11 * (i + 1));
            @(negedge clk);
        end
        bus.wb_wrs = 0;
        chk("vfs", bus.VFS, 32'h44332211);
        bus.instruccion = {4'h9, 4'b0000, 3'd0, 3'd2};
        bus.dec_rds = 1; bus.in_valid = 1;
        @(negedge clk);
        chk("rd_s2", 32'(bus.data_sca1), 32'h33);
        bus.instruccion = {4'hA, 2'b01, 8'h00};
        bus.sel_dest = 1; bus.dec_rds = 0; bus.dec_wrs = 1;
        @(negedge clk);
        chk("wr_s1_issca", 32'(bus.dest_is_sca), 32'd1);
        #1 chk("waw_stall", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 0; bus.dec_wrs = 0; bus.sel_dest = 0;

        // reset mid-stall
        bus.instruccion = {4'hB, 1'b0, 3'd5, 6'd0};
        bus.dec_wrv = 1; bus.in_valid = 1;
        @(negedge clk);
        bus.out_ready = 0; bus.in_valid = 0; bus.dec_wrv = 0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        bus.instruccion = {4'hC, 4'b0000, 3'd5, 3'd0};
        bus.dec_rdv = 1;
        #1 chk("pre_rst_stall", 32'(bus.in_ready), 32'd0);
        rst = 1; bus.out_ready = 1;
        @(negedge clk);
        rst = 0;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_vfs",   bus.VFS,            32'd0);
        bus.in_valid = 1;
        #1 chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("post_rst_issue", 32'(bus.out_valid), 32'd1);
        chk("post_rst_op",    32'(bus.opcode),    32'hC);
        chk("post_rst_data",  bus.data_vec1,      32'd0);
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/etapa_id_param.md
# etapa_id_param

Parametrised successor to the vector processor's decode stage (ID). It decodes a 14-bit instruction and holds the vector and scalar register banks. It adds three things the first-generation stage lacks: a registered ID/EX output with a valid/ready handshake, a scoreboard that stalls on RAW/WAW hazards against writebacks still in flight, and configurable lane count and element width. It sits between instruction fetch and the execute stage; the writeback port is driven from the last pipeline stage.

## Interface
Parameters:
- LANES, 4: vector elements per register; also the number of scalar registers exported on VFS.
- ELEM_W, 8: element and scalar width in bits.
- NVREG, 8: vector register count. Addressed by 3 bits; must be ≤8.
- NSREG, 8: scalar register count. Must be ≥LANES and ≤8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- instruccion  in  14  [13:10] opcode, [9:8] short destination, [8:6] long destination, [5:3] vector source 1 / shift, [2:0] vector source 2 / scalar source, [7:0] immediate.
- dec_rdv, dec_rds, dec_wrv, dec_wrs, sel_dest  in  1 each  per-instruction controls: read vector, read scalar, write vector, write scalar, select short destination.
- wb_wrv, wb_wrs  in  1 each  writeback enables.
- wb_dir  in  3  writeback register.
- wb_data_vec  in  LANES*ELEM_W  vector writeback data.
- wb_data_sca  in  ELEM_W  scalar writeback data.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  execute accepts.
- opcode  out  4;  dir_dest_out  out  3;  dest_is_vec, dest_is_sca  out  1 each.
- data_vec1, data_vec2  out  LANES*ELEM_W;  data_sca1  out  ELEM_W.
- inmediato  out  8;  shift  out  8  = {5'b0, instruccion[5:3]}.
- VFS  out  LANES*ELEM_W  combinational concatenation of scalar registers 0..LANES-1, with register 0 in the LSBs.

## Operation
- Destination: sel_dest=0 selects instruccion[8:6]; sel_dest=1 selects {1'b0, instruccion[9:8]}.
- Scoreboard: busy_v[NVREG] and busy_s[NSREG].
  - An accepted instruction with dec_wrv sets busy_v[dest]; with dec_wrs it sets busy_s[dest].
  - wb_wrv clears busy_v[wb_dir]; wb_wrs clears busy_s[wb_dir].
  - A clear of a non-busy register is harmless.
- hazard is asserted if any of these hold:
  - dec_rdv and busy_v[src1] or busy_v[src2];
  - dec_rds and busy_s[src];
  - dec_wrv and busy_v[dest];
  - dec_wrs and busy_s[dest].
- in_ready = !hazard && (!out_valid || out_ready). When in_valid is 0, in_ready still reflects the stall state.
- Register banks: synchronous write on wb_wrv/wb_wrs at the clock edge; asynchronous read feeds the ID/EX register.
- Same-cycle set and clear on one register: set wins, so the register stays busy.
- Out-of-range addresses (≥NVREG or ≥NSREG) read as 0 and are never marked busy.
- Capture: the output register loads on acceptance. When out_valid && out_ready && !accept, out_valid clears and the data fields hold their values.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
- Back-to-back issue at 1 instruction/cycle when there are no hazards and out_ready=1.
- Reset values: all registers 0, busy_* 0, out_valid 0, and all data outputs 0.
  - in_ready is 1 during reset if out_valid=0.
  - Reset asserted mid-stall discards the ID/EX contents and the scoreboard.
- A writeback at edge N updates the bank after edge N. Without bypass, a dependent read is accepted at edge N+1 at the earliest.

## Configuration
- WB_BYPASS_EN defined:
  - a writeback in the current cycle counts as clearing busy for hazard evaluation;
  - its data (wb_data_vec/wb_data_sca) is forwarded to any matching source being captured at the same edge.
  - Dependent issue then occurs at the same edge as the writeback.
- Not defined: no forwarding. Hazard uses only the registered busy bits, which adds 1 stall cycle after each writeback.

## Test plan
- Reset, then write vector register 3 = 0x04030201 via wb, then issue with dec_rdv, src1=3 -> one cycle later out_valid=1 and data_vec1=0x04030201.
- Issue with dec_wrv, dest=2, then an instruction reading v2 -> in_ready=0 until wb_wrv to register 2 with data 0xAABBCCDD.
  - With WB_BYPASS_EN: accepted at the writeback edge and data_vec2=0xAABBCCDD.
  - Without it: accepted one edge later with the same data.
- out_ready=0 while out_valid=1 -> in_ready=0 and outputs hold their values; out_ready=1 -> the next instruction loads after one edge.
- sel_dest=1 with instruccion[9:8]=2'b11 -> dir_dest_out=3'b011; sel_dest=0 with [8:6]=3'b101 -> 3'b101.
- Scalar writes of 0x11, 0x22, 0x33, 0x44 to registers 0..3 -> VFS=0x44332211.
- rst asserted while busy_v[5]=1 and out_valid=1 -> the next cycle has out_valid=0 and busy cleared; an instruction reading v5 is accepted immediately.
